prog_loader: RTL and testbench
==============================

// Module: prog_loader
// PURPOSE
//  UART-fed program memory that replaces the fixed ROM in front of the pipeline fetch stage.
//  Receives a framed 8N1 byte stream and writes 9-bit instructions into a DEPTH x IW RAM.
//  Serves instr combinationally on fetch_addr, and holds the CPU in reset while loading.
//  Runs on the free-running board clock (clk50), not the debounced step clock.
// PARAMETERS
//  CLK_HZ   50_000_000  clk frequency
//  BAUD     115200      serial rate; CPB = CLK_HZ/BAUD (integer division, 434 at defaults)
//  DEPTH    16          program words
//  AW       4           address width, DEPTH = 2**AW
//  IW       9           instruction width ({op[2:0], rd[1:0], src[3:0]})
//  SYNC     8'hA5       frame start byte
//  TO_BITS  64          inter-byte timeout, in bit periods
// PORTS
//  clk         in   1   board clock
//  rst         in   1   asynchronous, active-high reset
//  rx          in   1   UART line, idle high, asynchronous to clk
//  fetch_addr  in   AW  PC from fetch stage
//  instr       out  IW  instruction at fetch_addr (combinational)
//  cpu_hold    out  1   OR into processor reset while high
//  load_done   out  1   one-cycle pulse on accepted frame
//  load_err    out  1   sticky error flag
//  prog_len    out  AW+1 words in the valid program (0..DEPTH)
// BEHAVIOUR
//  Reset (async): FSM=IDLE, cpu_hold=1, load_done=0, load_err=0, prog_len=0, rx sync flops=1.
//   RAM is not reset. With prog_len=0, every fetch returns 0 (opcode 000 = no-op).
//  RX: 2-flop synchroniser. A falling edge in idle starts a byte. Sample at CPB/2; the start bit must still be 0, else drop silently.
//   Then 8 data bits (LSB first), each sampled CPB later. Then the stop bit.
//   Stop=1: pulse byte_vld for 1 cycle. Stop=0: framing error.
//  Frame: SYNC, N, {lo,hi} x N, CSUM. Word = {hi[0], lo}. CSUM = XOR of N and all lo/hi bytes.
//  FSM states and transitions:
//   IDLE: non-SYNC bytes are ignored. SYNC -> CNT, and set cpu_hold=1, load_err=0, prog_len=0.
//   CNT:  N==0 or N>DEPTH -> ERR. Otherwise wr_ptr=0, csum=N -> LO.
//   LO:   latch lo -> HI.
//   HI:   hi[7:1]!=0 -> ERR. Otherwise write RAM[wr_ptr]={hi[0],lo}, wr_ptr++.
//         Go to CSUM when wr_ptr+1==N, else back to LO.
//   CSUM: match -> DONE, mismatch -> ERR.
//   DONE: one cycle. prog_len=N, load_done=1, cpu_hold=0 -> IDLE.
//   ERR:  load_err=1, cpu_hold stays 1, prog_len stays 0 -> IDLE. The error flag stays set until the next SYNC.
//  Error sources: a framing error in any non-IDLE state -> ERR. In IDLE it is ignored.
//  Timeout: counter reloads on each byte_vld. After TO_BITS*CPB clks with no byte in CNT/LO/HI/CSUM -> ERR.
//  SYNC seen mid-frame is treated as data, not as a restart.
//  instr = (fetch_addr < prog_len) ? RAM[fetch_addr] : 0. Reads are combinational with zero latency.
//  A write and a read of the same address in the same cycle is never visible: cpu_hold=1 while writing.
//  A failed load leaves RAM partially overwritten. It is never executed because prog_len=0.
//  cpu_hold stays high from reset until the first successful load.
//  Reset during a frame aborts it. The bytes that follow are ignored until a new SYNC.
// TESTING
//  Send A5,03,{41,00},{52,00},{30,01},CSUM=XOR -> load_done pulse. prog_len=3, addr2 -> 9'h130, addr3 -> 0, cpu_hold=0.
//  Same frame with CSUM^1 -> load_err=1, cpu_hold=1, prog_len=0, every fetch_addr -> 0.
//  Send N=17 -> ERR immediately after the count byte. Send N=0 -> ERR.
//  Send hi byte 0x02 -> ERR. A byte with stop bit 0 mid-frame -> ERR.
//  Stop the stream after 3 bytes -> ERR after 64*434 clks, not earlier. Then a new valid frame -> load_err clears, load OK.
//  Garbage bytes 00,FF,5A before A5 -> ignored, frame accepted. rst after 4 bytes -> prog_len=0, cpu_hold=1.
//  A 16-word full frame -> wr_ptr wraps cleanly, addr15 is correct.
//  Baud tolerance: rx bit period ±2% -> all bytes received correctly.

Source files
------------

// File: rtl/prog_loader_if.sv
// Bus bundle between the UART program loader and the fetch stage / serial line.
// The loader sits on the slave modport; the CPU/board side drives rx and fetch_addr.
interface prog_loader_if #(
    parameter int AW = 4,
    parameter int IW = 9
) ();
    logic          rx;
    logic [AW-1:0] fetch_addr;
    logic [IW-1:0] instr;
    logic          cpu_hold;
    logic          load_done;
    logic          load_err;
    logic [AW:0]   prog_len;

    modport master (
        output rx, fetch_addr,
        input  instr, cpu_hold, load_done, load_err, prog_len
    );

    modport slave (
        input  rx, fetch_addr,
        output instr, cpu_hold, load_done, load_err, prog_len
    );
endinterface

// File: rtl/prog_loader.sv
// UART-fed program RAM: receives a framed 8N1 byte stream, writes 9-bit instructions,
// serves them combinationally to fetch and holds the CPU in reset until a load succeeds.
module prog_loader #(
    parameter int         CLK_HZ  = 50_000_000,
    parameter int         BAUD    = 115200,
    parameter int         DEPTH   = 16,
    parameter int         AW      = 4,
    parameter int         IW      = 9,
    parameter logic [7:0] SYNC    = 8'hA5,
    parameter int         TO_BITS = 64
) (
    input logic           clk,
    input logic           rst,
    prog_loader_if.slave  bus
);
    localparam int CPB    = CLK_HZ / BAUD;
    localparam int CW     = $clog2(CPB);
    localparam int TO_LIM = TO_BITS * CPB;
    localparam int TOW    = $clog2(TO_LIM);
    localparam logic [CW-1:0]  HALF_M1 = CW'(CPB / 2 - 1);
    localparam logic [CW-1:0]  FULL_M1 = CW'(CPB - 1);
    localparam logic [TOW-1:0] TO_M1   = TOW'(TO_LIM - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;
    typedef enum logic [2:0] {S_IDLE, S_CNT, S_LO, S_HI, S_CSUM, S_DONE, S_ERR} state_t;

    rxState_t      rxState_q;
    logic          rxS1_q, rxS2_q, rxS3_q;
    logic [CW-1:0] baudCnt_q;
    logic [2:0]    bitIdx_q;
    logic [7:0]    shift_q;
    logic          byteVld_q, frameErr_q;

    state_t         state_q, state_d;
    logic [AW:0]    cnt_q, cnt_d;
    logic [AW-1:0]  wrPtr_q, wrPtr_d;
    logic [7:0]     csum_q, csum_d;
    logic [7:0]     lo_q, lo_d;
    logic [AW:0]    progLen_q, progLen_d;
    logic           loadErr_q, loadErr_d;
    logic           cpuHold_q, cpuHold_d;
    logic [TOW-1:0] toCnt_q, toCnt_d;
    logic           ramWe;
    logic           inFrame;

    logic [IW-1:0] mem [DEPTH];

    // Receiver: a start is a high-to-low step of the synchronised line; sample mid-bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxS1_q     <= 1'b1;
            rxS2_q     <= 1'b1;
            rxS3_q     <= 1'b1;
            rxState_q  <= RX_IDLE;
            baudCnt_q  <= '0;
            bitIdx_q   <= '0;
            shift_q    <= '0;
            byteVld_q  <= 1'b0;
            frameErr_q <= 1'b0;
        end else begin
            rxS1_q     <= bus.rx;
            rxS2_q     <= rxS1_q;
            rxS3_q     <= rxS2_q;
            byteVld_q  <= 1'b0;
            frameErr_q <= 1'b0;
            case (rxState_q)
                RX_IDLE: begin
                    baudCnt_q <= '0;
                    if (rxS3_q && !rxS2_q) rxState_q <= RX_START;
                end
                RX_START: begin
                    if (baudCnt_q == HALF_M1) begin
                        baudCnt_q <= '0;
                        bitIdx_q  <= '0;
                        rxState_q <= rxS2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        baudCnt_q <= baudCnt_q + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (baudCnt_q == FULL_M1) begin
                        baudCnt_q <= '0;
                        shift_q   <= {rxS2_q, shift_q[7:1]};
                        bitIdx_q  <= bitIdx_q + 3'd1;
                        if (bitIdx_q == 3'd7) rxState_q <= RX_STOP;
                    end else begin
                        baudCnt_q <= baudCnt_q + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (baudCnt_q == FULL_M1) begin
                        baudCnt_q  <= '0;
                        rxState_q  <= RX_IDLE;
                        byteVld_q  <= rxS2_q;
                        frameErr_q <= !rxS2_q;
                    end else begin
                        baudCnt_q <= baudCnt_q + CW'(1);
                    end
                end
                default: rxState_q <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            wrPtr_q   <= '0;
            csum_q    <= '0;
            lo_q      <= '0;
            progLen_q <= '0;
            loadErr_q <= 1'b0;
            cpuHold_q <= 1'b1;
            toCnt_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wrPtr_q   <= wrPtr_d;
            csum_q    <= csum_d;
            lo_q      <= lo_d;
            progLen_q <= progLen_d;
            loadErr_q <= loadErr_d;
            cpuHold_q <= cpuHold_d;
            toCnt_q   <= toCnt_d;
        end
    end

    // RAM has no reset; prog_len gates every read so stale contents never reach fetch.
    always_ff @(posedge clk) begin
        if (ramWe) mem[wrPtr_q] <= {shift_q[0], lo_q};
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wrPtr_d   = wrPtr_q;
        csum_d    = csum_q;
        lo_d      = lo_q;
        progLen_d = progLen_q;
        loadErr_d = loadErr_q;
        cpuHold_d = cpuHold_q;
        ramWe     = 1'b0;
        inFrame   = (state_q == S_CNT) || (state_q == S_LO) ||
                    (state_q == S_HI)  || (state_q == S_CSUM);
        toCnt_d   = (inFrame && !byteVld_q) ? toCnt_q + TOW'(1) : '0;

        case (state_q)
            S_IDLE: begin
                if (byteVld_q && shift_q == SYNC) begin
                    state_d   = S_CNT;
                    cpuHold_d = 1'b1;
                    loadErr_d = 1'b0;
                    progLen_d = '0;
                end
            end
            S_CNT: begin
                if (byteVld_q) begin
                    if (shift_q == 8'd0 || shift_q > 8'(DEPTH)) begin
                        state_d = S_ERR;
                    end else begin
                        cnt_d   = shift_q[AW:0];
                        wrPtr_d = '0;
                        csum_d  = shift_q;
                        state_d = S_LO;
                    end
                end
            end
            S_LO: begin
                if (byteVld_q) begin
                    lo_d    = shift_q;
                    csum_d  = csum_q ^ shift_q;
                    state_d = S_HI;
                end
            end
            S_HI: begin
                if (byteVld_q) begin
                    if (shift_q[7:1] != 7'd0) begin
                        state_d = S_ERR;
                    end else begin
                        ramWe   = 1'b1;
                        wrPtr_d = wrPtr_q + AW'(1);
                        csum_d  = csum_q ^ shift_q;
                        state_d = (({1'b0, wrPtr_q} + (AW+1)'(1)) == cnt_q) ? S_CSUM : S_LO;
                    end
                end
            end
            S_CSUM: begin
                if (byteVld_q) state_d = (shift_q == csum_q) ? S_DONE : S_ERR;
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (inFrame && (frameErr_q || (!byteVld_q && toCnt_q == TO_M1))) begin
            state_d = S_ERR;
            ramWe   = 1'b0;
        end

        // Status flags change on entry so they line up with the DONE/ERR state cycle.
        if (state_d == S_ERR && state_q != S_ERR) begin
            loadErr_d = 1'b1;
            cpuHold_d = 1'b1;
            progLen_d = '0;
        end
        if (state_d == S_DONE) begin
            progLen_d = cnt_q;
            cpuHold_d = 1'b0;
        end
    end

    always_comb begin
        bus.instr     = ({1'b0, bus.fetch_addr} < progLen_q) ? mem[bus.fetch_addr] : '0;
        bus.cpu_hold  = cpuHold_q;
        bus.load_done = (state_q == S_DONE);
        bus.load_err  = loadErr_q;
        bus.prog_len  = progLen_q;
    end
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: drives UART frames bit by bit and checks status and fetch data.
// Runs with a shortened bit period (16 clocks) so the timeout is 64*16 = 1024 clocks.
`timescale 1ns/1ps
module tb_prog_loader;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    prog_loader_if #(.AW(4), .IW(9)) bus();

    prog_loader #(
        .CLK_HZ(1_600_000), .BAUD(100_000), .DEPTH(16), .AW(4), .IW(9),
        .SYNC(8'hA5), .TO_BITS(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int compared   = 0;
    int mismatched = 0;
    int doneCycles = 0;
    int d0;
    real bitNs = 160.0;
    logic [8:0] words [16];

    always @(posedge clk) if (bus.load_done === 1'b1) doneCycles++;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One 8N1 byte followed by one idle bit period.
    task automatic applyStimulus(input logic [7:0] b, input logic stopBit);
        bus.rx = 1'b0;
        #(bitNs);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            #(bitNs);
        end
        bus.rx = stopBit;
        #(bitNs);
        bus.rx = 1'b1;
        #(bitNs);
    endtask

    task automatic sendProgram(input int n, input logic [7:0] csumFlip);
        logic [7:0] cs;
        cs = 8'(n);
        applyStimulus(8'hA5, 1'b1);
        applyStimulus(8'(n), 1'b1);
        for (int i = 0; i < n; i++) begin
            applyStimulus(words[i][7:0], 1'b1);
            applyStimulus({7'd0, words[i][8]}, 1'b1);
            cs = cs ^ words[i][7:0] ^ {7'd0, words[i][8]};
        end
        applyStimulus(cs ^ csumFlip, 1'b1);
    endtask

    task automatic waitClocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkFetch(input string tag, input logic [3:0] addr, input logic [8:0] expected);
        @(negedge clk);
        bus.fetch_addr = addr;
        #1;
        checkOutput(tag, 32'(bus.instr), 32'(expected));
    endtask

    task automatic checkStatus(input string tag, input logic hold, input logic err, input logic [4:0] len);
        checkOutput({tag, "_hold"}, 32'(bus.cpu_hold), 32'(hold));
        checkOutput({tag, "_err"},  32'(bus.load_err), 32'(err));
        checkOutput({tag, "_len"},  32'(bus.prog_len), 32'(len));
    endtask

    initial begin
        rst = 1'b1;
        bus.rx = 1'b1;
        bus.fetch_addr = '0;
        waitClocks(3);
        checkStatus("reset", 1'b1, 1'b0, 5'd0);
        checkOutput("reset_done", 32'(bus.load_done), 32'd0);
        checkFetch("reset_fetch0", 4'd0, 9'h000);
        rst = 1'b0;
        waitClocks(20);

        // Basic 3-word load; checksum is 0x21.
        words[0] = 9'h041; words[1] = 9'h052; words[2] = 9'h130;
        d0 = doneCycles;
        sendProgram(3, 8'h00);
        waitClocks(4);
        checkOutput("ok3_done", 32'(doneCycles - d0), 32'd1);
        checkStatus("ok3", 1'b0, 1'b0, 5'd3);
        checkFetch("ok3_a0", 4'd0, 9'h041);
        checkFetch("ok3_a2", 4'd2, 9'h130);
        checkFetch("ok3_a3", 4'd3, 9'h000);

        // Same frame, wrong checksum.
        d0 = doneCycles;
        sendProgram(3, 8'h01);
        waitClocks(4);
        checkOutput("badcs_done", 32'(doneCycles - d0), 32'd0);
        checkStatus("badcs", 1'b1, 1'b1, 5'd0);
        for (int a = 0; a < 16; a += 5) checkFetch("badcs_fetch", 4'(a), 9'h000);

        // Count out of range: 17 and 0.
        applyStimulus(8'hA5, 1'b1);
        waitClocks(2);
        checkOutput("sync_clears_err", 32'(bus.load_err), 32'd0);
        applyStimulus(8'h11, 1'b1);
        checkOutput("n17_err", 32'(bus.load_err), 32'd1);
        applyStimulus(8'hA5, 1'b1);
        applyStimulus(8'h00, 1'b1);
        checkOutput("n0_err", 32'(bus.load_err), 32'd1);

        // Illegal hi byte.
        applyStimulus(8'hA5, 1'b1);
        applyStimulus(8'h01, 1'b1);
        applyStimulus(8'h41, 1'b1);
        checkOutput("hi_pre_err", 32'(bus.load_err), 32'd0);
        applyStimulus(8'h02, 1'b1);
        checkStatus("hi02", 1'b1, 1'b1, 5'd0);

        // Stop bit 0 mid-frame.
        applyStimulus(8'hA5, 1'b1);
        applyStimulus(8'h01, 1'b1);
        checkOutput("fe_pre_err", 32'(bus.load_err), 32'd0);
        applyStimulus(8'h41, 1'b0);
        checkOutput("fe_err", 32'(bus.load_err), 32'd1);

        // Stalled stream: timeout 1024 clocks after the last byte.
        applyStimulus(8'hA5, 1'b1);
        applyStimulus(8'h03, 1'b1);
        applyStimulus(8'h41, 1'b1);
        waitClocks(900);
        checkOutput("to_early", 32'(bus.load_err), 32'd0);
        waitClocks(200);
        checkOutput("to_fired", 32'(bus.load_err), 32'd1);
        d0 = doneCycles;
        sendProgram(3, 8'h00);
        waitClocks(4);
        checkOutput("to_recover_done", 32'(doneCycles - d0), 32'd1);
        checkStatus("to_recover", 1'b0, 1'b0, 5'd3);

        // Garbage before SYNC; new 2-word program (checksum 0x25).
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'hFF, 1'b1);
        applyStimulus(8'h5A, 1'b1);
        words[0] = 9'h112; words[1] = 9'h034;
        d0 = doneCycles;
        sendProgram(2, 8'h00);
        waitClocks(4);
        checkOutput("garb_done", 32'(doneCycles - d0), 32'd1);
        checkStatus("garb", 1'b0, 1'b0, 5'd2);
        checkFetch("garb_a0", 4'd0, 9'h112);
        checkFetch("garb_a1", 4'd1, 9'h034);
        checkFetch("garb_a2", 4'd2, 9'h000);

        // SYNC value as a data byte.
        words[0] = 9'h0A5;
        sendProgram(1, 8'h00);
        waitClocks(4);
        checkStatus("syncdata", 1'b0, 1'b0, 5'd1);
        checkFetch("syncdata_a0", 4'd0, 9'h0A5);

        // Reset after four bytes; the rest of the frame must be ignored.
        applyStimulus(8'hA5, 1'b1);
        applyStimulus(8'h03, 1'b1);
        applyStimulus(8'h41, 1'b1);
        applyStimulus(8'h00, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        waitClocks(2);
        checkStatus("midrst", 1'b1, 1'b0, 5'd0);
        rst = 1'b0;
        d0 = doneCycles;
        applyStimulus(8'h52, 1'b1);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h30, 1'b1);
        applyStimulus(8'h01, 1'b1);
        applyStimulus(8'h21, 1'b1);
        waitClocks(4);
        checkOutput("midrst_tail_done", 32'(doneCycles - d0), 32'd0);
        checkStatus("midrst_tail", 1'b1, 1'b0, 5'd0);

        // Full 16-word program.
        for (int i = 0; i < 16; i++) words[i] = {i[0], 8'(i * 29 + 3)};
        d0 = doneCycles;
        sendProgram(16, 8'h00);
        waitClocks(4);
        checkOutput("full_done", 32'(doneCycles - d0), 32'd1);
        checkStatus("full", 1'b0, 1'b0, 5'd16);
        checkFetch("full_a0", 4'd0, 9'h003);
        checkFetch("full_a8", 4'd8, 9'h0EB);
        checkFetch("full_a15", 4'd15, 9'h1B6);

        // Baud tolerance: +2% then -2% bit period.
        bitNs = 163.2;
        words[0] = 9'h1C3;
        d0 = doneCycles;
        sendProgram(1, 8'h00);
        waitClocks(4);
        checkOutput("slow_done", 32'(doneCycles - d0), 32'd1);
        checkStatus("slow", 1'b0, 1'b0, 5'd1);
        checkFetch("slow_a0", 4'd0, 9'h1C3);
        bitNs = 156.8;
        words[0] = 9'h055; words[1] = 9'h1AA;
        d0 = doneCycles;
        sendProgram(2, 8'h00);
        waitClocks(4);
        checkOutput("fast_done", 32'(doneCycles - d0), 32'd1);
        checkStatus("fast", 1'b0, 1'b0, 5'd2);
        checkFetch("fast_a1", 4'd1, 9'h1AA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
